// File: rtl/image_window_gen_pkg.sv
// Shared defaults and FSM encoding for the 3x3 image window generator.
package image_window_gen_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/image_window_gen_line_buffer.sv
// One image row of pixels: synchronous write and asynchronous read at the same column index.
module line_buffer #(
  parameter int DEPTH  = 28,
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx] <= wr_data;
    end
  end

  assign rd_data = mem[idx];

endmodule

// File: rtl/image_window_gen.sv
// Raster-order frame walker that assembles 3x3 pixel windows from two line buffers
// and hands each valid-position window downstream over valid/ready.
module image_window_gen
  import image_window_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rd_data,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [9*DATA_W-1:0]      win_data,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam logic [ROW_W-1:0] LAST_R = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] LAST_C = COL_W'(IMG_W - 1);

  state_t state, state_nxt;

  logic [ROW_W-1:0]  r;
  logic [COL_W-1:0]  c;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic [DATA_W-1:0] win_pix_p1 [3][3];

  logic last_pix, emit_pos, handshake, advance, lb_wr;

  assign last_pix  = (r == LAST_R) && (c == LAST_C);
  assign emit_pos  = (r >= ROW_W'(2)) && (c >= COL_W'(2));
  assign handshake = (state == S_EMIT) && win_ready;
  assign advance   = ((state == S_WAIT) && !emit_pos && !last_pix) ||
                     (handshake && !last_pix);
  assign lb_wr     = (state == S_WAIT);

  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .IDX_W(COL_W)) lb0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (lb_wr),
    .idx     (c),
    .wr_data (mem_rd_data),
    .rd_data (lb0_rd)
  );

  // lb1 takes the row that lb0 is about to overwrite, so it always lags by one row
  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .IDX_W(COL_W)) lb1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (lb_wr),
    .idx     (c),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (emit_pos)      state_nxt = S_EMIT;
        else if (last_pix) state_nxt = S_DONE;
        else               state_nxt = S_FETCH;
      end
      S_EMIT:  if (win_ready) state_nxt = last_pix ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    mem_rd_en = (state == S_FETCH);
    mem_addr  = (state == S_FETCH) ? addr : '0;
    win_valid = (state == S_EMIT);
  end

  // Raster position; addr tracks r*IMG_W+c incrementally instead of multiplying
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r    <= '0;
      c    <= '0;
      addr <= '0;
    end else if ((state == S_IDLE) && start) begin
      r    <= '0;
      c    <= '0;
      addr <= '0;
    end else if (advance) begin
      addr <= addr + ADDR_W'(1);
      if (c == LAST_C) begin
        c <= '0;
        r <= r + ROW_W'(1);
      end else begin
        c <= c + COL_W'(1);
      end
    end
  end

  // Window stage: shift left, new right column is {lb1[c], lb0[c], fresh pixel}
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) win_pix_p1[i][j] <= '0;
      win_row <= '0;
      win_col <= '0;
    end else if (state == S_WAIT) begin
      for (int i = 0; i < 3; i++) begin
        win_pix_p1[i][0] <= win_pix_p1[i][1];
        win_pix_p1[i][1] <= win_pix_p1[i][2];
      end
      win_pix_p1[0][2] <= lb1_rd;
      win_pix_p1[1][2] <= lb0_rd;
      win_pix_p1[2][2] <= mem_rd_data;
      win_row <= r - ROW_W'(2);
      win_col <= c - COL_W'(2);
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win_data[DATA_W*(3*i+j) +: DATA_W] = win_pix_p1[i][j];
  end

endmodule

// File: tb/tb_image_window_gen.sv
// Bench for image_window_gen: a 4x4 instance for timing/stall/reset corners and a
// default 28x28 instance run against a window reference model with random backpressure.
module tb_image_window_gen;

  typedef struct {
    logic [71:0] data;
    int          row;
    int          col;
    int          cyc;
  } win_t;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  // 4x4 instance signals
  logic        rst_s, start_s, busy_s, done_s, mem_rd_en_s, win_valid_s, win_ready_s;
  logic [3:0]  mem_addr_s;
  logic [7:0]  mem_rd_data_s;
  logic [71:0] win_data_s;
  logic [1:0]  win_row_s, win_col_s;

  // 28x28 instance signals
  logic        rst_l, start_l, busy_l, done_l, mem_rd_en_l, win_valid_l, win_ready_l;
  logic [9:0]  mem_addr_l;
  logic [7:0]  mem_rd_data_l;
  logic [71:0] win_data_l;
  logic [4:0]  win_row_l, win_col_l;

  win_t tbl [4];

  image_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut_s (
    .clk(clk), .rst(rst_s), .start(start_s), .busy(busy_s), .done(done_s),
    .mem_rd_en(mem_rd_en_s), .mem_addr(mem_addr_s), .mem_rd_data(mem_rd_data_s),
    .win_valid(win_valid_s), .win_ready(win_ready_s), .win_data(win_data_s),
    .win_row(win_row_s), .win_col(win_col_s)
  );

  image_window_gen dut_l (
    .clk(clk), .rst(rst_l), .start(start_l), .busy(busy_l), .done(done_l),
    .mem_rd_en(mem_rd_en_l), .mem_addr(mem_addr_l), .mem_rd_data(mem_rd_data_l),
    .win_valid(win_valid_l), .win_ready(win_ready_l), .win_data(win_data_l),
    .win_row(win_row_l), .win_col(win_col_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel memories: memory[k] = k mod 256, one-cycle read latency
  always @(posedge clk) if (mem_rd_en_s) mem_rd_data_s <= 8'(mem_addr_s);
  always @(posedge clk) if (mem_rd_en_l) mem_rd_data_l <= 8'(mem_addr_l);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int b0, b1, b2, b3, b4, b5, b6, b7, b8);
    logic [71:0] v;
    v = {8'(b8), 8'(b7), 8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    return v;
  endfunction

  function automatic logic [71:0] model_win(input int r0, input int c0, input int w);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[8*(3*i+j) +: 8] = 8'((r0 + i) * w + c0 + j);
    return v;
  endfunction

  // mode 0: plain, 1: stall window 2 for 5 cycles, 2: reset in EMIT of window 3,
  // 3: extra start pulses while busy
  task automatic run_small(input int mode);
    win_t q[$];
    win_t e;
    int   nwin, ndone, nstall;
    bit   prev_valid, fin;
    for (int i = 0; i < 4; i++) q.push_back(tbl[i]);
    nwin = 0; ndone = 0; nstall = 0; prev_valid = 0; fin = 0;
    @(negedge clk);
    start_s = 1'b1;
    win_ready_s = 1'b1;
    for (int cyc = 1; cyc <= 120 && !fin; cyc++) begin
      @(negedge clk);
      start_s = (mode == 3) && (cyc == 9 || cyc == 24 || cyc == 30);
      win_ready_s = 1'b1;
      if (cyc == 1) begin
        chk("first_rd_en", mem_rd_en_s, 1);
        chk("first_addr", mem_addr_s, 0);
      end
      if (mode == 2 && win_valid_s && nwin == 2) begin
        rst_s = 1'b0;
        #1;
        chk("rst_valid", win_valid_s, 0);
        chk("rst_busy", busy_s, 0);
        chk("rst_done", done_s, 0);
        chk("rst_rd_en", mem_rd_en_s, 0);
        chk("rst_addr", mem_addr_s, 0);
        chk("rst_data", win_data_s, 0);
        chk("rst_rowcol", {win_row_s, win_col_s}, 0);
        @(negedge clk);
        rst_s = 1'b1;
        repeat (8) begin
          @(negedge clk);
          if (done_s) ndone++;
        end
        chk("rst_no_done", ndone, 0);
        chk("rst_idle_busy", busy_s, 0);
        fin = 1;
      end else begin
        if (win_valid_s && !prev_valid && q.size() > 0)
          chk("win_cycle", cyc, q[0].cyc + ((mode == 1 && nwin > 1) ? 5 : 0));
        if (mode == 1 && nwin == 1 && nstall > 0)
          chk("stall_valid", win_valid_s, 1);
        if (mode == 1 && win_valid_s && nwin == 1 && nstall < 5) begin
          win_ready_s = 1'b0;
          nstall++;
          chk("stall_data", win_data_s, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
          chk("stall_rd_en", mem_rd_en_s, 0);
        end
        prev_valid = win_valid_s;
        if (win_valid_s && win_ready_s) begin
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("win_data", win_data_s, e.data);
            chk("win_row", win_row_s, e.row);
            chk("win_col", win_col_s, e.col);
          end
          nwin++;
        end
        if (done_s) begin
          ndone++;
          chk("done_cycle", cyc, 37 + ((mode == 1) ? 5 : 0));
        end else if (ndone > 0) begin
          chk("after_done_busy", busy_s, 0);
          fin = 1;
        end
      end
    end
    start_s = 1'b0;
    if (mode != 2) begin
      chk("win_count", nwin, 4);
      chk("done_count", ndone, 1);
      chk("sb_empty", q.size(), 0);
    end
  endtask

  task automatic run_large();
    win_t q[$];
    win_t e;
    int   nwin, ndone;
    bit   fin;
    for (int r0 = 0; r0 < 26; r0++)
      for (int c0 = 0; c0 < 26; c0++)
        q.push_back('{model_win(r0, c0, 28), r0, c0, 0});
    nwin = 0; ndone = 0; fin = 0;
    @(negedge clk);
    start_l = 1'b1;
    for (int cyc = 1; cyc <= 20000 && !fin; cyc++) begin
      @(negedge clk);
      start_l = 1'b0;
      win_ready_l = 1'($urandom_range(0, 1));
      if (win_valid_l && win_ready_l) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("big_win", {win_row_l, win_col_l, win_data_l}, {5'(e.row), 5'(e.col), e.data});
        end
        nwin++;
      end
      if (done_l) ndone++;
      else if (ndone > 0) fin = 1;
    end
    chk("big_count", nwin, 676);
    chk("big_done", ndone, 1);
    chk("big_busy", busy_l, 0);
    chk("big_sb_empty", q.size(), 0);
  endtask

  initial begin
    rst_s = 1'b0; rst_l = 1'b0;
    start_s = 1'b0; start_l = 1'b0;
    win_ready_s = 1'b1; win_ready_l = 1'b0;
    tbl[0] = '{pack9(0, 1, 2, 4, 5, 6, 8, 9, 10),     0, 0, 23};
    tbl[1] = '{pack9(1, 2, 3, 5, 6, 7, 9, 10, 11),    0, 1, 26};
    tbl[2] = '{pack9(4, 5, 6, 8, 9, 10, 12, 13, 14),  1, 0, 33};
    tbl[3] = '{pack9(5, 6, 7, 9, 10, 11, 13, 14, 15), 1, 1, 36};
    repeat (2) @(negedge clk);
    chk("reset_busy", busy_s, 0);
    chk("reset_done", done_s, 0);
    chk("reset_valid", win_valid_s, 0);
    chk("reset_rd_en", mem_rd_en_s, 0);
    chk("reset_addr", mem_addr_s, 0);
    chk("reset_data", win_data_s, 0);
    chk("reset_big_busy", busy_l, 0);
    rst_s = 1'b1; rst_l = 1'b1;
    @(negedge clk);
    run_small(0);
    run_small(1);
    run_small(2);
    run_small(0);
    run_small(3);
    run_large();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
